mips_mem_dump: RTL and testbench
================================

MIPS_MEM_DUMP -- requirements
Module: mips_mem_dump

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, word-address width of the dumped memory (64 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  first word address; sampled with start.
REQ-007 word_count  input  ADDR_WIDTH+1  number of words to dump (0..2^ADDR_WIDTH); sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 cpu_hold  output  1  stalls the CPU PC/writes while high; equals busy.
REQ-010 mem_rd_en  output  1  memory read strobe.
REQ-011 mem_rd_addr  output  ADDR_WIDTH  memory read address.
REQ-012 mem_rd_data  input  DATA_WIDTH  read data, valid one cycle after mem_rd_en (synchronous read).
REQ-013 out_valid  output  1; out_ready  input  1: valid/ready output handshake.
REQ-014 out_data  output  DATA_WIDTH; out_addr  output  ADDR_WIDTH; out_last  output  1 (final word).
REQ-015 done  output  1  one-cycle pulse at dump completion.
REQ-016 checksum  output  DATA_WIDTH  running sum of dumped words (see Configuration).

Function
REQ-017 FSM SHALL have states IDLE, READ, CAPT, SEND, DONE.
REQ-018 IDLE: start=1 and word_count>0 -> READ; start=1 and word_count=0 -> DONE; else stay.
REQ-019 READ: mem_rd_en=1, mem_rd_addr=current address, for exactly one cycle -> CAPT.
REQ-020 CAPT: register mem_rd_data into out_data, address into out_addr -> SEND.
REQ-021 SEND: out_valid=1; out_data/out_addr/out_last SHALL hold stable until out_valid&&out_ready.
REQ-022 On handshake: remaining count decrements, address increments modulo 2^ADDR_WIDTH; remaining>0 -> READ, else -> DONE.
REQ-023 out_last SHALL be high in SEND only for the final word.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 First out_valid SHALL occur 3 cycles after the edge that samples start; steady-state throughput one word per 3 cycles with out_ready held high.
REQ-026 start while busy SHALL be ignored; base_addr/word_count changes while busy SHALL have no effect.
REQ-027 word_count of 2^ADDR_WIDTH SHALL dump every word once, wrapping through address 0.
REQ-028 mem_rd_en SHALL be low in all states except READ.

Reset
REQ-029 rst SHALL force IDLE at the next edge, from any state, including mid-dump.
REQ-030 Reset values: busy, cpu_hold, mem_rd_en, out_valid, out_last, done = 0; mem_rd_addr, out_data, out_addr, checksum = 0.

Configuration
REQ-031 Macro MIPS_DUMP_CHECKSUM_EN defined: checksum clears on accepted start, adds each word at its handshake (modulo 2^DATA_WIDTH), holds after DONE.
REQ-032 Macro undefined: checksum SHALL be constant 0 and no adder logic SHALL be present.

Structure
REQ-033 Package mips_dbg_pkg SHALL hold the FSM state enum and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-034 Sub-module dump_checksum (clear, add-enable, data -> sum) SHALL be instantiated only under MIPS_DUMP_CHECKSUM_EN.

Verification (memory preloaded memory[i]=i; checksum checks with macro defined)
REQ-035 base=4, count=3, out_ready=1 -> out_data/out_addr 4,5,6; out_last only on 6; done pulse once; checksum 15.
REQ-036 base=62, count=4 -> out_addr 62,63,0,1; out_data 62,63,0,1; checksum 126.
REQ-037 count=0 -> no mem_rd_en, no out_valid; busy high one cycle; done pulses 1 cycle after start.
REQ-038 base=10, count=2, out_ready low 5 cycles during first SEND -> out_data=10 stable, no mem_rd_en until handshake, then 11 delivered.
REQ-039 rst asserted in CAPT of a count=8 dump -> next cycle all outputs at reset values, cpu_hold=0; new start base=0,count=1 yields out_data 0.
REQ-040 second start pulse (base=20) during a base=3,count=2 dump -> only addresses 3,4 emitted, single done.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared types and default sizes for the MIPS debug memory-dump block.
// Defines the dump FSM state encoding used by mips_mem_dump.
package mips_dbg_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAPT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/dump_checksum.sv
// Running modulo-2^DATA_WIDTH sum of dumped words; cleared at the start of each dump.
// Only built when MIPS_DUMP_CHECKSUM_EN is defined.
module dump_checksum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (add_en) begin
      r_sum <= r_sum + data;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/mips_mem_dump.sv
// Streams a window of a synchronous-read memory out over a valid/ready port while holding the CPU.
// Optional checksum of the streamed words is enabled with the macro MIPS_DUMP_CHECKSUM_EN.
module mips_mem_dump
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  dump_state_t           r_state;
  dump_state_t           w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  w_start_accept;
  logic                  w_handshake;
  logic                  w_last_word;

  assign w_start_accept = (r_state == ST_IDLE) && start;
  assign w_handshake    = (r_state == ST_SEND) && out_ready;
  assign w_last_word    = (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      // Inputs are latched only on an accepted start, so changes while busy are ignored.
      if (w_start_accept) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
      end
      if (r_state == ST_CAPT) begin
        r_out_data <= mem_rd_data;
        r_out_addr <= r_addr;
      end
      if (w_handshake) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    mem_rd_en    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (word_count != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        mem_rd_en    = 1'b1;
        w_next_state = ST_CAPT;
      end
      ST_CAPT: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = w_last_word;
        if (w_handshake) begin
          w_next_state = w_last_word ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign cpu_hold    = busy;
  assign mem_rd_addr = r_addr;
  assign out_data    = r_out_data;
  assign out_addr    = r_out_addr;

`ifdef MIPS_DUMP_CHECKSUM_EN
  dump_checksum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checksum (
    .clk   (clk),
    .rst   (rst),
    .clear (w_start_accept),
    .add_en(w_handshake),
    .data  (r_out_data),
    .sum   (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mips_mem_dump.sv
// Directed bench for mips_mem_dump against a 64-word memory preloaded with memory[i]=i.
// Checksum expectations follow MIPS_DUMP_CHECKSUM_EN (0 when the feature is disabled).
module tb_mips_mem_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  word_count;
  logic        busy;
  logic        cpu_hold;
  logic        mem_rd_en;
  logic [5:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_addr;
  logic        out_last;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] mem [64];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          done_mark;

  always #5 clk = ~clk;

  mips_mem_dump #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .done       (done),
    .checksum   (checksum)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = 32'(i);

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_dump(input int base, input int cnt);
    base_addr  = 6'(base);
    word_count = 7'(cnt);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Waits (bounded) for out_valid, checks the word, then lets one handshake edge pass.
  task automatic expect_word(input string tag, input int a, input bit last);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_addr"}, 32'(out_addr), 32'(a));
    chk({tag, "_data"}, out_data, 32'(a));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_rden"}, 32'(mem_rd_en), 32'd0);
    tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_rden"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdaddr"}, 32'(mem_rd_addr), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_oaddr"}, 32'(out_addr), 32'd0);
    chk({tag, "_csum"}, checksum, 32'd0);
  endtask

  function automatic logic [31:0] csum_exp(input logic [31:0] v);
`ifdef MIPS_DUMP_CHECKSUM_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state("rst");

    // base=4, count=3, latency and word order
    done_mark = done_cnt;
    start_dump(4, 3);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_hold", 32'(cpu_hold), 32'd1);
    chk("a_rden", 32'(mem_rd_en), 32'd1);
    chk("a_rdaddr", 32'(mem_rd_addr), 32'd4);
    chk("a_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("a_capt_rden", 32'(mem_rd_en), 32'd0);
    chk("a_capt_valid", 32'(out_valid), 32'd0);
    tick();
    chk("a_first_valid", 32'(out_valid), 32'd1);
    expect_word("a0", 4, 1'b0);
    expect_word("a1", 5, 1'b0);
    expect_word("a2", 6, 1'b1);
    chk("a_done", 32'(done), 32'd1);
    chk("a_done_busy", 32'(busy), 32'd1);
    tick();
    chk("a_idle_busy", 32'(busy), 32'd0);
    chk("a_idle_done", 32'(done), 32'd0);
    chk("a_csum", checksum, csum_exp(32'd15));
    chk("a_done_cnt", 32'(done_cnt - done_mark), 32'd1);

    // wrap through address 0
    start_dump(62, 4);
    expect_word("b0", 62, 1'b0);
    expect_word("b1", 63, 1'b0);
    expect_word("b2", 0, 1'b0);
    expect_word("b3", 1, 1'b1);
    tick();
    chk("b_csum", checksum, csum_exp(32'd126));

    // zero-length dump
    done_mark = done_cnt;
    start_dump(9, 0);
    chk("c_busy", 32'(busy), 32'd1);
    chk("c_done", 32'(done), 32'd1);
    chk("c_rden", 32'(mem_rd_en), 32'd0);
    chk("c_valid", 32'(out_valid), 32'd0);
    tick();
    chk("c_busy_end", 32'(busy), 32'd0);
    chk("c_done_end", 32'(done), 32'd0);
    chk("c_done_cnt", 32'(done_cnt - done_mark), 32'd1);
    chk("c_csum", checksum, 32'd0);

    // backpressure in first SEND
    out_ready = 1'b0;
    start_dump(10, 2);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("d_hold_valid", 32'(out_valid), 32'd1);
      chk("d_hold_data", out_data, 32'd10);
      chk("d_hold_rden", 32'(mem_rd_en), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    expect_word("d0", 10, 1'b0);
    expect_word("d1", 11, 1'b1);
    tick();

    // reset in CAPT of an 8-word dump
    start_dump(16, 8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("mid");
    start_dump(0, 1);
    expect_word("e0", 0, 1'b1);
    chk("e_done", 32'(done), 32'd1);
    tick();

    // second start while busy is ignored
    done_mark = done_cnt;
    start_dump(3, 2);
    base_addr  = 6'd20;
    word_count = 7'd5;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    expect_word("f0", 3, 1'b0);
    expect_word("f1", 4, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("f_quiet_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("f_done_cnt", 32'(done_cnt - done_mark), 32'd1);

    // full memory dump starting mid-array
    start_dump(5, 64);
    for (int i = 0; i < 64; i++) begin
      expect_word("g", (5 + i) % 64, (i == 63));
    end
    tick();
    chk("g_csum", checksum, csum_exp(32'd2016));
    chk("g_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
